// File: rtl/axi_port_protocol_checker.sv
// Passive AXI protocol checker for one NoC master port: handshake stability, W beat
// accounting, response accounting and outstanding limits. Define AXI_CHK_TIMEOUT_EN for stall timeouts.
module axi_port_protocol_checker #(
    parameter int LEN_W           = 4,
    parameter int AW_PLD_W        = 64,
    parameter int W_PLD_W         = 69,
    parameter int AR_PLD_W        = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic                               AWVALID,
    input  logic                               AWREADY,
    input  logic [LEN_W-1:0]                   AWLEN,
    input  logic [AW_PLD_W-1:0]                AW_PLD,
    input  logic                               WVALID,
    input  logic                               WREADY,
    input  logic                               WLAST,
    input  logic [W_PLD_W-1:0]                 W_PLD,
    input  logic                               BVALID,
    input  logic                               BREADY,
    input  logic                               ARVALID,
    input  logic                               ARREADY,
    input  logic [AR_PLD_W-1:0]                AR_PLD,
    input  logic                               RVALID,
    input  logic                               RREADY,
    input  logic                               RLAST,
    input  logic                               err_clr,
    output logic [8:0]                         err_vec,
    output logic                               err_valid,
    output logic [3:0]                         err_first,
    output logic [CNT_W-1:0]                   err_count,
    output logic [$clog2(MAX_OUTSTANDING):0]   wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OUT_W = PTR_W + 1;
    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

    function automatic logic [3:0] first_idx(input logic [8:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcnt(input logic [8:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [3:0] n);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W+1)'(n);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic aw_fire_s, w_fire_s, b_fire_s, ar_fire_s, r_fire_s;
    assign aw_fire_s = AWVALID & AWREADY;
    assign w_fire_s  = WVALID & WREADY;
    assign b_fire_s  = BVALID & BREADY;
    assign ar_fire_s = ARVALID & ARREADY;
    assign r_fire_s  = RVALID & RREADY;

    logic                aw_stalled_r, w_stalled_r, ar_stalled_r;
    logic [AW_PLD_W-1:0] aw_cap_r;
    logic [W_PLD_W-1:0]  w_cap_r;
    logic [AR_PLD_W-1:0] ar_cap_r;

    logic [LEN_W-1:0] fifo_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [OUT_W-1:0] fifo_cnt_r;
    logic [LEN_W-1:0] wbeat_r;
    logic [OUT_W-1:0] wcomp_r;
    logic [OUT_W-1:0] wr_out_r, rd_out_r;

    logic [8:0]       err_vec_r;
    logic             err_valid_r;
    logic [3:0]       err_first_r;
    logic [CNT_W-1:0] err_count_r;

    logic             fifo_empty_s, fifo_full_s, fifo_push_s, fifo_pop_s;
    logic [LEN_W-1:0] head_s;
    logic             w_tracked_s, w_exp_last_s, w_end_s;
    logic             wr_inc_s, wr_dec_s, rd_inc_s, rd_dec_s;
    logic             timeout_s;
    logic [8:0]       err_set_s;

    // Burst bookkeeping: a burst ends on WLAST or on the beat AWLEN says is last.
    always_comb begin
        fifo_empty_s = (fifo_cnt_r == {OUT_W{1'b0}});
        fifo_full_s  = (fifo_cnt_r == MAX_CNT);
        head_s       = fifo_mem_r[rd_ptr_r];
        w_tracked_s  = w_fire_s & ~fifo_empty_s;
        w_exp_last_s = (wbeat_r == head_s);
        w_end_s      = w_tracked_s & (WLAST | w_exp_last_s);
        fifo_push_s  = aw_fire_s & ~fifo_full_s;
        fifo_pop_s   = w_end_s;
        wr_inc_s     = aw_fire_s & (wr_out_r != MAX_CNT);
        wr_dec_s     = b_fire_s & (wr_out_r != {OUT_W{1'b0}});
        rd_inc_s     = ar_fire_s & (rd_out_r != MAX_CNT);
        rd_dec_s     = r_fire_s & RLAST & (rd_out_r != {OUT_W{1'b0}});
    end

    // Per-rule violation events detected on the current edge.
    always_comb begin
        err_set_s    = 9'd0;
        err_set_s[0] = aw_stalled_r & (~AWVALID | (AW_PLD != aw_cap_r));
        err_set_s[1] = w_stalled_r & (~WVALID | (W_PLD != w_cap_r));
        err_set_s[2] = ar_stalled_r & (~ARVALID | (AR_PLD != ar_cap_r));
        err_set_s[3] = w_tracked_s & (WLAST != w_exp_last_s);
        err_set_s[4] = b_fire_s & (wcomp_r == {OUT_W{1'b0}});
        err_set_s[5] = r_fire_s & (rd_out_r == {OUT_W{1'b0}});
        err_set_s[6] = (aw_fire_s & (wr_out_r == MAX_CNT)) | (ar_fire_s & (rd_out_r == MAX_CNT));
        err_set_s[7] = w_fire_s & fifo_empty_s;
        err_set_s[8] = timeout_s;
    end

    // Stall flags and payload snapshots for the stability rules.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_stalled_r <= 1'b0;
            w_stalled_r  <= 1'b0;
            ar_stalled_r <= 1'b0;
            aw_cap_r     <= '0;
            w_cap_r      <= '0;
            ar_cap_r     <= '0;
        end else begin
            aw_stalled_r <= AWVALID & ~AWREADY;
            w_stalled_r  <= WVALID & ~WREADY;
            ar_stalled_r <= ARVALID & ~ARREADY;
            if (AWVALID & ~AWREADY) aw_cap_r <= AW_PLD;
            if (WVALID & ~WREADY)   w_cap_r  <= W_PLD;
            if (ARVALID & ~ARREADY) ar_cap_r <= AR_PLD;
        end
    end

    // AWLEN FIFO, W beat counter and write-complete counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_r[i] <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            wbeat_r    <= '0;
            wcomp_r    <= '0;
        end else begin
            if (fifo_push_s) begin
                fifo_mem_r[wr_ptr_r] <= AWLEN;
                wr_ptr_r             <= wr_ptr_r + 1'b1;
            end
            if (fifo_pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (w_end_s)          wbeat_r <= '0;
            else if (w_tracked_s) wbeat_r <= wbeat_r + 1'b1;
            case ({w_end_s & (wcomp_r != {OUT_W{1'b1}}), b_fire_s & (wcomp_r != {OUT_W{1'b0}})})
                2'b10:   wcomp_r <= wcomp_r + 1'b1;
                2'b01:   wcomp_r <= wcomp_r - 1'b1;
                default: wcomp_r <= wcomp_r;
            endcase
        end
    end

    // Outstanding transaction counters; a same-cycle increment and decrement cancel.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_out_r <= '0;
            rd_out_r <= '0;
        end else begin
            case ({wr_inc_s, wr_dec_s})
                2'b10:   wr_out_r <= wr_out_r + 1'b1;
                2'b01:   wr_out_r <= wr_out_r - 1'b1;
                default: wr_out_r <= wr_out_r;
            endcase
            case ({rd_inc_s, rd_dec_s})
                2'b10:   rd_out_r <= rd_out_r + 1'b1;
                2'b01:   rd_out_r <= rd_out_r - 1'b1;
                default: rd_out_r <= rd_out_r;
            endcase
        end
    end

    // Sticky error reporting; err_clr drops any events seen in the same cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET || err_clr) begin
            err_vec_r   <= 9'd0;
            err_valid_r <= 1'b0;
            err_first_r <= 4'd0;
            err_count_r <= '0;
        end else begin
            err_vec_r   <= err_vec_r | err_set_s;
            err_valid_r <= err_valid_r | (|err_set_s);
            if (!err_valid_r && (|err_set_s)) err_first_r <= first_idx(err_set_s);
            err_count_r <= sat_add(err_count_r, popcnt(err_set_s));
        end
    end

`ifdef AXI_CHK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_PRE   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [4:0]      to_valid_s, to_ready_s, to_hit_s;
    logic [TO_W-1:0] to_cnt_r [5];

    assign to_valid_s = {RVALID, BVALID, ARVALID, WVALID, AWVALID};
    assign to_ready_s = {RREADY, BREADY, ARREADY, WREADY, AWREADY};

    // A channel hits the limit on the single edge its counter reaches TIMEOUT_CYCLES.
    always_comb begin
        to_hit_s = 5'd0;
        for (int i = 0; i < 5; i++) begin
            to_hit_s[i] = to_valid_s[i] & ~to_ready_s[i] & (to_cnt_r[i] == TO_PRE);
        end
        timeout_s = |to_hit_s;
    end

    // Stall counters hold at the limit so each episode reports only once.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < 5; i++) begin
            if (ARESET || !to_valid_s[i] || to_ready_s[i]) to_cnt_r[i] <= '0;
            else if (to_cnt_r[i] != TO_LIMIT)              to_cnt_r[i] <= to_cnt_r[i] + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = |TIMEOUT_CYCLES;
    assign timeout_s            = 1'b0;
`endif

    assign err_vec        = err_vec_r;
    assign err_valid      = err_valid_r;
    assign err_first      = err_first_r;
    assign err_count      = err_count_r;
    assign wr_outstanding = wr_out_r;
    assign rd_outstanding = rd_out_r;

endmodule

// File: tb/tb_axi_port_protocol_checker.sv
// Directed bench for axi_port_protocol_checker: a vector table for single-cycle
// handshakes plus hand-written multi-cycle sequences (stability, W count, reset, timeout).
module tb_axi_port_protocol_checker;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic         ARVALID, ARREADY, RVALID, RREADY, RLAST, err_clr;
    logic [3:0]   AWLEN;
    logic [63:0]  AW_PLD, AR_PLD;
    logic [68:0]  W_PLD;
    logic [8:0]   err_vec;
    logic         err_valid;
    logic [3:0]   err_first;
    logic [15:0]  err_count;
    logic [3:0]   wr_outstanding, rd_outstanding;

    int total = 0;
    int bad   = 0;

`ifdef AXI_CHK_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    axi_port_protocol_checker #(.TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AW_PLD(AW_PLD),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .W_PLD(W_PLD),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .AR_PLD(AR_PLD),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .err_clr(err_clr), .err_vec(err_vec), .err_valid(err_valid),
        .err_first(err_first), .err_count(err_count),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    always #5 ACLK = ~ACLK;

    // control word bits: {awv,awr, wv,wr,wl, bv,br, arv,arr, rv,rr,rl, clr}
    localparam logic [12:0] AWF = 13'h1800, WF = 13'h0600, WL = 13'h0100, BF = 13'h00C0;
    localparam logic [12:0] ARF = 13'h0030, RF = 13'h000C, RL = 13'h0002, CLR = 13'h0001;

    typedef struct {
        string       nm;
        logic [12:0] ctl;
        logic [3:0]  len;
        logic [8:0]  ev;
        logic [3:0]  ef;
        logic [15:0] ec;
        logic [3:0]  wo;
        logic [3:0]  ro;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [12:0] ctl, logic [3:0] len, logic [8:0] ev,
                                logic [3:0] ef, logic [15:0] ec, logic [3:0] wo, logic [3:0] ro);
        vec_t v;
        v.nm = nm; v.ctl = ctl; v.len = len; v.ev = ev; v.ef = ef; v.ec = ec; v.wo = wo; v.ro = ro;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        {AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY} = 7'd0;
        {ARVALID, ARREADY, RVALID, RREADY, RLAST, err_clr}        = 6'd0;
        AWLEN = 4'd0; AW_PLD = 64'd0; W_PLD = 69'd0; AR_PLD = 64'd0;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic rst_dut();
        idle();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
    endtask

    task automatic check_err(input string nm, input logic [8:0] ev, input logic [3:0] ef,
                             input logic [15:0] ec);
        check({nm, ".err_vec"}, 32'(err_vec), 32'(ev));
        check({nm, ".err_valid"}, 32'(err_valid), 32'(ev != 9'd0));
        check({nm, ".err_first"}, 32'(err_first), 32'(ef));
        check({nm, ".err_count"}, 32'(err_count), 32'(ec));
    endtask

    initial begin
        // Single-cycle handshake table, run directly after a reset.
        vecs.push_back(mk("aw_len3", AWF, 4'd3, 9'h000, 4'd0, 16'd0, 4'd1, 4'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("w_beat", WF, 4'd0, 9'h000, 4'd0, 16'd0, 4'd1, 4'd0));
        vecs.push_back(mk("w_last", WF | WL, 4'd0, 9'h000, 4'd0, 16'd0, 4'd1, 4'd0));
        vecs.push_back(mk("b_resp", BF, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'd0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk("ar_fill", ARF, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'(i)));
        vecs.push_back(mk("ar_over", ARF, 4'd0, 9'h040, 4'd6, 16'd1, 4'd0, 4'd8));
        vecs.push_back(mk("clr", CLR, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'd8));
        for (int i = 7; i >= 2; i--)
            vecs.push_back(mk("r_drain", RF | RL, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'(i)));
        vecs.push_back(mk("ar_r_same", ARF | RF | RL, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'd2));
        vecs.push_back(mk("r_mid", RF, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'd2));
        vecs.push_back(mk("b_clr", BF | CLR, 4'd0, 9'h000, 4'd0, 16'd0, 4'd0, 4'd2));
        vecs.push_back(mk("b_orphan", BF, 4'd0, 9'h010, 4'd4, 16'd1, 4'd0, 4'd2));

        idle();
        ARESET = 1'b1;
        step();
        step();
        ARESET = 1'b0;
        check_err("reset", 9'h000, 4'd0, 16'd0);
        check("reset.wr_out", 32'(wr_outstanding), 32'd0);
        check("reset.rd_out", 32'(rd_outstanding), 32'd0);

        foreach (vecs[i]) begin
            {AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
             ARVALID, ARREADY, RVALID, RREADY, RLAST, err_clr} = vecs[i].ctl;
            AWLEN = vecs[i].len;
            step();
            check_err(vecs[i].nm, vecs[i].ev, vecs[i].ef, vecs[i].ec);
            check({vecs[i].nm, ".wr_out"}, 32'(wr_outstanding), 32'(vecs[i].wo));
            check({vecs[i].nm, ".rd_out"}, 32'(rd_outstanding), 32'(vecs[i].ro));
        end

        // Payload stability on AW/W/AR: payload change or VALID drop while stalled.
        for (int ch = 0; ch < 3; ch++) begin
            for (int drop = 0; drop < 2; drop++) begin
                rst_dut();
                AW_PLD = 64'h1234; W_PLD = 69'h1234; AR_PLD = 64'h1234;
                AWVALID = (ch == 0); WVALID = (ch == 1); ARVALID = (ch == 2);
                step();
                check_err("stall_hold", 9'h000, 4'd0, 16'd0);
                if (drop != 0) begin
                    {AWVALID, WVALID, ARVALID} = 3'd0;
                end else begin
                    AW_PLD = 64'h1235; W_PLD = 69'h1235; AR_PLD = 64'h1235;
                end
                step();
                check_err("stall_break", 9'(1 << ch), 4'(ch), 16'd1);
            end
        end

        // Early WLAST on a 2-beat burst, then one legal and one orphan B.
        rst_dut();
        {AWVALID, AWREADY} = 2'b11; AWLEN = 4'd1;
        step();
        {AWVALID, AWREADY} = 2'b00;
        {WVALID, WREADY, WLAST} = 3'b111;
        step();
        check_err("w_early_last", 9'h008, 4'd3, 16'd1);
        check("w_early_last.wr_out", 32'(wr_outstanding), 32'd1);
        {WVALID, WREADY, WLAST} = 3'b000;
        {BVALID, BREADY} = 2'b11;
        step();
        check_err("b_legal", 9'h008, 4'd3, 16'd1);
        check("b_legal.wr_out", 32'(wr_outstanding), 32'd0);
        step();
        check_err("b_extra", 9'h018, 4'd3, 16'd2);
        {BVALID, BREADY} = 2'b00;

        // Missing WLAST on the final beat of a 2-beat burst.
        rst_dut();
        {AWVALID, AWREADY} = 2'b11; AWLEN = 4'd1;
        step();
        {AWVALID, AWREADY} = 2'b00;
        {WVALID, WREADY} = 2'b11;
        step();
        check_err("w_beat1", 9'h000, 4'd0, 16'd0);
        step();
        check_err("w_no_last", 9'h008, 4'd3, 16'd1);

        // Reset in the middle of a burst discards the FIFO and all errors.
        rst_dut();
        {AWVALID, AWREADY, ARVALID, ARREADY} = 4'b1111; AWLEN = 4'd3;
        step();
        {AWVALID, AWREADY, ARREADY} = 3'b000;
        {WVALID, WREADY} = 2'b11;
        AR_PLD = 64'hA;
        step();
        AR_PLD = 64'hB;
        step();
        check_err("pre_reset", 9'h004, 4'd2, 16'd1);
        check("pre_reset.wr_out", 32'(wr_outstanding), 32'd1);
        check("pre_reset.rd_out", 32'(rd_outstanding), 32'd1);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check_err("mid_reset", 9'h000, 4'd0, 16'd0);
        check("mid_reset.wr_out", 32'(wr_outstanding), 32'd0);
        check("mid_reset.rd_out", 32'(rd_outstanding), 32'd0);
        idle();
        {WVALID, WREADY, WLAST} = 3'b111;
        step();
        check_err("w_after_reset", 9'h080, 4'd7, 16'd1);

        // B stalled for the timeout window and beyond.
        rst_dut();
        BVALID = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("timeout_pre", 32'(err_vec[8]), 32'd0);
        step();
        check("timeout_hit", 32'(err_vec[8]), 32'(TO_EN));
        check("timeout_first", 32'(err_first), TO_EN ? 32'd8 : 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("timeout_once", 32'(err_count), 32'(TO_EN));
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_port_protocol_checker.md
Name: axi_port_protocol_checker

Overview:
- Synthesizable, parametrised AXI protocol checker attached passively to one master port of the 4-master/7-slave NoC.
- Generalises the per-master interface handshake assertions into hardware.
- Tracks outstanding bursts, W beat counts, response accounting and payload stability.
- Reports sticky error flags, a first-error code and a saturating error count; usable in simulation, emulation and silicon debug.

Parameters:
- LEN_W, 4, width of AxLEN (bursts of 1..2^LEN_W beats).
- AW_PLD_W, 64, width of concatenated AW payload bus checked for stability.
- W_PLD_W, 69, width of concatenated W payload bus (data+strb+last+user).
- AR_PLD_W, 64, width of concatenated AR payload bus.
- MAX_OUTSTANDING, 8, AW-length FIFO depth and outstanding-counter limit (power of two, >=2).
- CNT_W, 16, width of saturating error counter.
- TIMEOUT_CYCLES, 1024, stall limit (used only with optional feature).

Ports:
- ACLK in 1: clock.
- ARESET in 1: reset.
- AWVALID in 1: write address valid.
- AWREADY in 1: write address ready.
- AWLEN in LEN_W: burst length.
- AW_PLD in AW_PLD_W: AW payload.
- WVALID in 1: write data valid.
- WREADY in 1: write data ready.
- WLAST in 1: write last.
- W_PLD in W_PLD_W: W payload.
- BVALID in 1: write response valid.
- BREADY in 1: write response ready.
- ARVALID in 1: read address valid.
- ARREADY in 1: read address ready.
- AR_PLD in AR_PLD_W: AR payload.
- RVALID in 1: read data valid.
- RREADY in 1: read data ready.
- RLAST in 1: read last.
- err_clr in 1: clears err_vec, err_first, err_valid and err_count.
- err_vec out 9: sticky per-rule error flags.
- err_valid out 1: at least one error latched.
- err_first out 4: bit index of first error (lowest index wins on a tie).
- err_count out CNT_W: saturating count of error events.
- wr_outstanding out log2(MAX_OUTSTANDING)+1: accepted AW not yet answered by B.
- rd_outstanding out log2(MAX_OUTSTANDING)+1: accepted AR not yet ended by RLAST.

Behaviour:
- Clocking and reset:
  - Single clock ACLK.
  - Reset is synchronous and active-high: ARESET sampled at posedge ACLK.
  - All outputs, counters, FIFO and pipeline registers are 0 after reset.
  - Reset mid-burst discards all tracking state; no errors are raised for the aborted traffic.
- Latency: every error is registered and visible one cycle after the violating edge.
- Handshake: channel X fires when X_VALID && X_READY at posedge.
- Stall tracking: a per-channel "stalled" register is set when VALID && !READY, and the payload is captured.
- Error rules (err_vec bits):
  - 0: AW stalled last cycle and, this cycle, AWVALID=0 or AW_PLD != captured.
  - 1: same rule for W (W_PLD).
  - 2: same rule for AR (AR_PLD).
  - 3: W beat count mismatch. The beat counter counts W fires against the head of the AWLEN FIFO.
    - Error if WLAST=1 on a beat other than AWLEN+1.
    - Error if WLAST=0 on beat AWLEN+1.
    - In either case the FIFO pops and the counter clears at the point the burst is considered ended.
  - 4: B fires while the write-complete counter is 0. This counter increments when a W burst ends and decrements on B fire.
  - 5: R fires while rd_outstanding = 0.
  - 6: AW fires with wr_outstanding = MAX_OUTSTANDING, or AR fires with rd_outstanding = MAX_OUTSTANDING. The count does not increment beyond the limit.
  - 7: W fires while the AWLEN FIFO is empty. NoC masters never send W before AW.
  - 8: timeout (optional feature only).
- Counters:
  - wr_outstanding: +1 on AW fire, -1 on B fire.
  - rd_outstanding: +1 on AR fire, -1 on R fire with RLAST.
  - Simultaneous increment and decrement leaves the count unchanged.
  - No decrement below 0; the error is flagged instead.
- Error reporting:
  - err_count adds the number of bits newly raised this cycle (not popcount of err_vec).
  - err_count saturates at all-ones.
  - err_first is captured only when err_valid transitions 0->1.
  - err_clr wins over same-cycle new errors (those are dropped).
  - Tracking state is not affected by err_clr.

Optional Feature:
- Macro AXI_CHK_TIMEOUT_EN.
- When defined:
  - Per-channel stall counters for AW, W, AR, B and R increment while VALID && !READY and reset on fire or on VALID=0.
  - When any counter reaches TIMEOUT_CYCLES, err_vec[8] is set, once per stall episode.
- When undefined: no counters are instantiated and err_vec[8] is tied to 0.

Test Plan:
- Reset, then AW AWLEN=3 followed by 4 W beats with WLAST on the 4th, then B -> err_vec=0, wr_outstanding 0->1->0.
- AWVALID=1, AWREADY=0, AW_PLD changed next cycle -> err_vec[0]=1 one cycle later, err_first=0, err_count=1.
- AWLEN=1, WLAST on beat 1 -> err_vec[3]=1. Then a BVALID/BREADY fire with the write-complete counter at 0 -> err_vec[4]=1. Result err_count=2, err_first=3.
- 9 AR fires with no R (MAX_OUTSTANDING=8) -> err_vec[6]=1, rd_outstanding=8. Then err_clr -> err_vec=0, err_count=0, rd_outstanding still 8.
- Simultaneous AR fire and RLAST fire with rd_outstanding=2 -> stays 2, no error. Assert ARESET mid-burst -> all outputs 0 next cycle.
- With AXI_CHK_TIMEOUT_EN and TIMEOUT_CYCLES=16: BVALID held, BREADY=0 for 16 cycles -> err_vec[8]=1 exactly once. Without the macro -> err_vec[8]=0.
